// File: rtl/i2s_audio_tx.sv
// I2S serializer: one-deep stereo holding register feeding a frame register that is
// shifted out MSB-first with self-generated BCLK/LRCK; flags underrun and overrun.
module i2s_audio_tx #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 4
) (
  input  logic                     AUDIO_CLK,
  input  logic                     reset_data,
  input  logic                     sample_valid,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  output logic                     aud_bclk,
  output logic                     aud_lrck,
  output logic                     aud_dat,
  output logic                     frame_start,
  output logic                     underrun,
  output logic                     overrun
);

  localparam int DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);

  logic [DW-1:0]            r_div_cnt;
  logic [BW-1:0]            r_bit_cnt;
  logic                     r_hold_full;
  logic [AUD_BIT_DEPTH-1:0] r_hold_l, r_hold_r;
  logic [AUD_BIT_DEPTH-1:0] r_frame_l, r_frame_r;

  logic                     w_edge, w_wrap, w_lrck_next, w_dat_next;
  logic [DW-1:0]            w_div_next;
  logic [BW-1:0]            w_bit_next, w_pos;
  logic [AUD_BIT_DEPTH-1:0] w_sample;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_edge      = (r_div_cnt == DIV_LAST);
    w_div_next  = w_edge ? '0 : r_div_cnt + 1'b1;
    w_wrap      = w_edge && (r_bit_cnt == BIT_LAST);
    w_bit_next  = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    w_lrck_next = (w_bit_next >= SLOT);
    w_pos       = w_lrck_next ? (w_bit_next - SLOT) : w_bit_next;
    w_sample    = w_lrck_next ? r_frame_r : r_frame_l;
    w_dat_next  = 1'b0;
    // Slot position p carries sample bit [DEPTH-p]; position 0 and trailing bits stay 0.
    for (int i = 0; i < AUD_BIT_DEPTH; i++) begin
      if (w_pos == BW'(AUD_BIT_DEPTH - i)) w_dat_next = w_sample[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge AUDIO_CLK) begin
    if (reset_data) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= BIT_LAST;
      r_hold_full <= 1'b0;
      // NOTE: sample registers are reset because an underrun after reset repeats them.
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_frame_l   <= '0;
      r_frame_r   <= '0;
      aud_bclk    <= 1'b0;
      aud_lrck    <= 1'b1;
      aud_dat     <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_next;
      aud_bclk    <= (w_div_next >= DIV_HALF);
      frame_start <= w_wrap;
      underrun    <= w_wrap && !r_hold_full;
      overrun     <= sample_valid && r_hold_full && !w_wrap;

      if (w_edge) begin
        r_bit_cnt <= w_bit_next;
        aud_lrck  <= w_lrck_next;
        aud_dat   <= w_dat_next;
      end

      // Frame takes the old hold contents even if a new sample lands this same cycle.
      if (w_wrap && r_hold_full) begin
        r_frame_l <= r_hold_l;
        r_frame_r <= r_hold_r;
      end

      if (sample_valid) begin
        r_hold_l    <= lsound_in;
        r_hold_r    <= rsound_in;
        r_hold_full <= 1'b1;
      end else if (w_wrap) begin
        r_hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: timing, serial framing, underrun/overrun and reset
// behaviour with hand-computed expectations at 24-bit samples in 32-bit slots, BCLK = 4 clk.
module tb_i2s_audio_tx;

  logic        clk = 1'b0;
  logic        reset_data = 1'b1;
  logic        sample_valid = 1'b0;
  logic [23:0] lsound_in = '0;
  logic [23:0] rsound_in = '0;
  logic        aud_bclk, aud_lrck, aud_dat, frame_start, underrun, overrun;

  int n_vec = 0;
  int n_err = 0;
  int ov_cnt = 0;
  int ur_cnt = 0;

  i2s_audio_tx #(.AUD_BIT_DEPTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
    .AUDIO_CLK   (clk),
    .reset_data  (reset_data),
    .sample_valid(sample_valid),
    .lsound_in   (lsound_in),
    .rsound_in   (rsound_in),
    .aud_bclk    (aud_bclk),
    .aud_lrck    (aud_lrck),
    .aud_dat     (aud_dat),
    .frame_start (frame_start),
    .underrun    (underrun),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun === 1'b1)  ov_cnt++;
    if (underrun === 1'b1) ur_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset for one cycle (sample_valid asserted to show it is ignored), then check outputs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset_data   = 1'b1;
    sample_valid = 1'b1;
    lsound_in    = 24'h777777;
    rsound_in    = 24'h777777;
    @(negedge clk);
    sample_valid = 1'b0;
    check(tag, {26'd0, aud_bclk, aud_lrck, aud_dat, frame_start, underrun, overrun},
          32'b010000);
    reset_data = 1'b0;
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    sample_valid = 1'b1;
    lsound_in    = l;
    rsound_in    = r;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Counts negedges until frame_start is seen (0 if already high).
  task automatic wait_fs(output int n);
    n = 0;
    while (frame_start !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("fs_timeout", 32'd0, 32'd1);
  endtask

  // Waits for a frame, then samples each of the 64 bits in the middle of BCLK-high.
  task automatic capture(output int n, output logic ur, output logic [23:0] l,
                         output logic [23:0] r, output int bad);
    int off;
    int p;
    wait_fs(n);
    ur  = underrun;
    bad = 0;
    l   = '0;
    r   = '0;
    off = 0;
    for (int k = 0; k < 64; k++) begin
      while (off < 4 * k + 2) begin
        @(negedge clk);
        off++;
      end
      if (aud_bclk !== 1'b1) bad++;
      if (aud_lrck !== (k >= 32)) bad++;
      p = k % 32;
      if (p >= 1 && p <= 24) begin
        if (k < 32) l[24-p] = aud_dat;
        else        r[24-p] = aud_dat;
      end else if (aud_dat !== 1'b0) begin
        bad++;
      end
    end
  endtask

  initial begin
    int          n, bad, ov0, ur0;
    logic        ur;
    logic [23:0] l, r;
    logic [7:0]  bpat;
    logic        fs1;

    // 1: reset state, BCLK shape, LRCK period, frame cadence with underruns
    do_reset("reset_vals");
    wait_fs(n);
    check("first_fs_delay", n, 4);
    check("first_underrun", {31'd0, underrun}, 1);
    for (int i = 0; i < 8; i++) begin
      bpat[i] = aud_bclk;
      if (i == 1) fs1 = frame_start;
      @(negedge clk);
    end
    check("bclk_pattern", {24'd0, bpat}, 32'hCC);
    check("fs_one_cycle", {31'd0, fs1}, 0);
    repeat (119) @(negedge clk);
    check("lrck_left_end", {31'd0, aud_lrck}, 0);
    @(negedge clk);
    check("lrck_right_start", {31'd0, aud_lrck}, 1);
    wait_fs(n);
    check("frame_period_half", n, 128);
    check("second_underrun", {31'd0, underrun}, 1);

    // 2: one stereo sample serialized MSB first with zero padding
    ov0 = ov_cnt;
    send(24'hA50F3C, 24'h800001);
    capture(n, ur, l, r, bad);
    check("t2_fs_delay", n, 255);
    check("t2_left", {8'd0, l}, 32'hA50F3C);
    check("t2_right", {8'd0, r}, 32'h800001);
    check("t2_no_underrun", {31'd0, ur}, 0);
    check("t2_framing", bad, 0);
    check("t2_no_overrun", ov_cnt - ov0, 0);

    // 3: no new samples: the same frame repeats with underrun each time
    for (int f = 0; f < 3; f++) begin
      capture(n, ur, l, r, bad);
      check("t3_period", n, 2);
      check("t3_left", {8'd0, l}, 32'hA50F3C);
      check("t3_right", {8'd0, r}, 32'h800001);
      check("t3_underrun", {31'd0, ur}, 1);
      check("t3_framing", bad, 0);
    end

    // 4: two strobes in one frame: one overrun, newest sample wins
    wait_fs(n);
    ov0 = ov_cnt;
    send(24'h000001, 24'h00000A);
    repeat (10) @(negedge clk);
    send(24'h000002, 24'h00000B);
    capture(n, ur, l, r, bad);
    check("t4_overrun", ov_cnt - ov0, 1);
    check("t4_left", {8'd0, l}, 32'h000002);
    check("t4_right", {8'd0, r}, 32'h00000B);
    check("t4_no_underrun", {31'd0, ur}, 0);

    // 5: strobe exactly on the frame-load cycle with the hold register full
    wait_fs(n);
    send(24'h123456, 24'h654321);
    ov0 = ov_cnt;
    ur0 = ur_cnt;
    repeat (254) @(negedge clk);
    send(24'hFEDCBA, 24'h0F0F0F);
    capture(n, ur, l, r, bad);
    check("t5_fs_on_load", n, 0);
    check("t5_old_left", {8'd0, l}, 32'h123456);
    check("t5_old_right", {8'd0, r}, 32'h654321);
    capture(n, ur, l, r, bad);
    check("t5_new_left", {8'd0, l}, 32'hFEDCBA);
    check("t5_new_right", {8'd0, r}, 32'h0F0F0F);
    check("t5_no_overrun", ov_cnt - ov0, 0);
    check("t5_no_underrun", ur_cnt - ur0, 0);

    // 6: one-cycle reset mid left slot aborts the frame and empties the hold register
    wait_fs(n);
    send(24'h111111, 24'h222222);
    repeat (40) @(negedge clk);
    do_reset("t6_reset_vals");
    capture(n, ur, l, r, bad);
    check("t6_fs_delay", n, 4);
    check("t6_underrun", {31'd0, ur}, 1);
    check("t6_left_zero", {8'd0, l}, 0);
    check("t6_right_zero", {8'd0, r}, 0);
    check("t6_framing", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
